// File: rtl/video_timing_gen.sv
`default_nettype none
// video_timing_gen: raster counters, syncs, active-draw, new-frame pulse, frame count
// and a latency-matching delay line for sync/active-draw. Rev 1.0

module video_timing_gen #(
   parameter  int H_ACTIVE    = 1280,
   parameter  int H_FP        = 110,
   parameter  int H_SYNC      = 40,
   parameter  int H_BP        = 220,
   parameter  int V_ACTIVE    = 720,
   parameter  int V_FP        = 5,
   parameter  int V_SYNC      = 5,
   parameter  int V_BP        = 20,
   parameter  int HS_POL      = 1,
   parameter  int VS_POL      = 1,
   parameter  int FRAME_WRAP  = 60,
   parameter  int SCALE_SHIFT = 0,
   parameter  int ALIGN_DELAY = 0,
   localparam int H_TOTAL     = H_ACTIVE + H_FP + H_SYNC + H_BP,
   localparam int V_TOTAL     = V_ACTIVE + V_FP + V_SYNC + V_BP,
   localparam int HW          = $clog2(H_TOTAL),
   localparam int VW          = $clog2(V_TOTAL),
   localparam int FW          = $clog2(FRAME_WRAP)
) (
   input  logic          clk_pixel_in,
   input  logic          rst_in,
   output logic [HW-1:0] hcount_out,
   output logic [VW-1:0] vcount_out,
   output logic [HW-1:0] x_out,
   output logic [VW-1:0] y_out,
   output logic          hs_out,
   output logic          vs_out,
   output logic          ad_out,
   output logic          nf_out,
   output logic [FW-1:0] fc_out,
   output logic          hs_d_out,
   output logic          vs_d_out,
   output logic          ad_d_out
);

   localparam logic [HW-1:0] c_H_LAST   = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0] c_V_LAST   = VW'(V_TOTAL - 1);
   localparam logic [HW-1:0] c_H_ACT    = HW'(H_ACTIVE);
   localparam logic [VW-1:0] c_V_ACT    = VW'(V_ACTIVE);
   localparam logic [HW-1:0] c_HS_START = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] c_HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] c_VS_START = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] c_VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [FW-1:0] c_FC_LAST  = FW'(FRAME_WRAP - 1);
   localparam logic          c_HS_ON    = (HS_POL != 0);
   localparam logic          c_VS_ON    = (VS_POL != 0);

   if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
       V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
       (HS_POL != 0 && HS_POL != 1) || (VS_POL != 0 && VS_POL != 1) ||
       FRAME_WRAP < 2 || SCALE_SHIFT < 0 || SCALE_SHIFT > 4 ||
       ALIGN_DELAY < 0 || ALIGN_DELAY > 15) begin : g_param_err
      $error("video_timing_gen: parameter out of range");
   end

   logic [HW-1:0] hcount_q, hcount_d, x_q, x_d;
   logic [VW-1:0] vcount_q, vcount_d, y_q, y_d;
   logic [FW-1:0] fc_q, fc_d;
   logic          hs_q, hs_d, vs_q, vs_d, ad_q, ad_d, nf_q, nf_d;

   // Flags are decoded from the next position so they stay aligned with the counters.
   always_comb begin
      hcount_d = (hcount_q == c_H_LAST) ? '0 : hcount_q + HW'(1);
      vcount_d = vcount_q;
      if (hcount_q == c_H_LAST)
         vcount_d = (vcount_q == c_V_LAST) ? '0 : vcount_q + VW'(1);
      x_d  = hcount_d >> SCALE_SHIFT;
      y_d  = vcount_d >> SCALE_SHIFT;
      hs_d = (hcount_d >= c_HS_START && hcount_d < c_HS_END) ? c_HS_ON : ~c_HS_ON;
      vs_d = (vcount_d >= c_VS_START && vcount_d < c_VS_END) ? c_VS_ON : ~c_VS_ON;
      ad_d = (hcount_d < c_H_ACT) && (vcount_d < c_V_ACT);
      nf_d = (hcount_d == '0) && (vcount_d == c_V_ACT);
      fc_d = fc_q;
      if (nf_d)
         fc_d = (fc_q == c_FC_LAST) ? '0 : fc_q + FW'(1);
   end

   always_ff @(posedge clk_pixel_in) begin
      if (!rst_in) begin
         hcount_q <= c_H_LAST;
         vcount_q <= c_V_LAST;
         x_q      <= c_H_LAST >> SCALE_SHIFT;
         y_q      <= c_V_LAST >> SCALE_SHIFT;
         hs_q     <= ~c_HS_ON;
         vs_q     <= ~c_VS_ON;
         ad_q     <= 1'b0;
         nf_q     <= 1'b0;
         fc_q     <= '0;
      end else begin
         hcount_q <= hcount_d;
         vcount_q <= vcount_d;
         x_q      <= x_d;
         y_q      <= y_d;
         hs_q     <= hs_d;
         vs_q     <= vs_d;
         ad_q     <= ad_d;
         nf_q     <= nf_d;
         fc_q     <= fc_d;
      end
   end

   assign hcount_out = hcount_q;
   assign vcount_out = vcount_q;
   assign x_out      = x_q;
   assign y_out      = y_q;
   assign hs_out     = hs_q;
   assign vs_out     = vs_q;
   assign ad_out     = ad_q;
   assign nf_out     = nf_q;
   assign fc_out     = fc_q;

   if (ALIGN_DELAY == 0) begin : g_no_delay
      assign hs_d_out = hs_q;
      assign vs_d_out = vs_q;
      assign ad_d_out = ad_q;
   end else begin : g_delay
      logic [2:0] dly_q [ALIGN_DELAY];

      always_ff @(posedge clk_pixel_in) begin
         if (!rst_in) begin
            for (int i = 0; i < ALIGN_DELAY; i++)
               dly_q[i] <= {~c_HS_ON, ~c_VS_ON, 1'b0};
         end else begin
            dly_q[0] <= {hs_q, vs_q, ad_q};
            for (int i = 1; i < ALIGN_DELAY; i++)
               dly_q[i] <= dly_q[i-1];
         end
      end

      assign {hs_d_out, vs_d_out, ad_d_out} = dly_q[ALIGN_DELAY-1];
   end

endmodule

`default_nettype wire
